// File: rtl/prio_req_arbiter_8_if.sv
// prio_req_arbiter_8_if: request/grant bundle between 8 requesters and the arbiter.
// Signals:
//   req       [7:0] requester -> arbiter, req[i] held high while requester i wants the resource
//   gnt       [7:0] arbiter -> requesters, one-hot grant, zero when idle
//   gnt_id    [2:0] arbiter -> requesters, index of current grant, 0 when idle
//   gnt_valid       arbiter -> requesters, high while a grant is active
//   timeout         arbiter -> requesters, one-cycle pulse when a grant is revoked by timeout
// Modports: master (requester side), slave (arbiter side).
interface prio_req_arbiter_8_if;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;
    modport master (output req, input gnt, gnt_id, gnt_valid, timeout);
    modport slave  (input req, output gnt, gnt_id, gnt_valid, timeout);
endinterface

// File: rtl/prio_req_arbiter_8.sv
// prio_req_arbiter_8: 8-requester arbiter with held grants, hold timeout and registered outputs.
// Ports:
//   clk   rising-edge clock
//   rst_n synchronous active-low reset
//   bus   prio_req_arbiter_8_if.slave (req in; gnt, gnt_id, gnt_valid, timeout out)
// Parameters:
//   MAX_HOLD maximum consecutive grant cycles per holder, 0 disables the timeout
//   HOLD_W   hold counter width, MAX_HOLD < 2**HOLD_W
// Optional feature: define PRIO_ARB_ROUND_ROBIN_EN for rotating priority
// (search starts below the last granted index); undefined gives fixed priority,
// highest index wins.
module prio_req_arbiter_8 #(
    parameter int MAX_HOLD = 16,
    parameter int HOLD_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    prio_req_arbiter_8_if.slave  bus
);
    typedef enum logic {IDLE, GRANT} state_t;
    state_t            state_q;
    logic [7:0]        gnt_q;
    logic [2:0]        gnt_id_q;
    logic              gnt_valid_q;
    logic              timeout_q;
    logic [HOLD_W-1:0] hold_cnt_q;
    logic [7:0]        mask_q;
    logic [7:0]        eligible;
    logic [2:0]        pick_id;
`ifdef PRIO_ARB_ROUND_ROBIN_EN
    logic [2:0]        ptr_q;
`endif
    assign eligible = bus.req & ~mask_q;
    always_comb begin
        pick_id = '0;
`ifdef PRIO_ARB_ROUND_ROBIN_EN
        // Later iterations override earlier ones, so ptr-1 ends up with top
        // priority and the pointer itself (k=8) with the lowest.
        for (int k = 8; k >= 1; k--)
            if (eligible[3'(ptr_q - 3'(k))]) pick_id = 3'(ptr_q - 3'(k));
`else
        for (int i = 0; i < 8; i++)
            if (eligible[i]) pick_id = 3'(i);
`endif
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            gnt_id_q    <= '0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
            hold_cnt_q  <= '0;
            mask_q      <= '0;
`ifdef PRIO_ARB_ROUND_ROBIN_EN
            ptr_q       <= '0;
`endif
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (|eligible) begin
                        gnt_q       <= 8'(1) << pick_id;
                        gnt_id_q    <= pick_id;
                        gnt_valid_q <= 1'b1;
                        hold_cnt_q  <= HOLD_W'(1);
                        mask_q      <= '0;
                        state_q     <= GRANT;
`ifdef PRIO_ARB_ROUND_ROBIN_EN
                        ptr_q       <= pick_id;
`endif
                    end else if (|bus.req) begin
                        // Only masked requesters remain: spend one round idle.
                        mask_q <= '0;
                    end
                end
                GRANT: begin
                    // Release takes precedence over a coincident timeout.
                    if (!bus.req[gnt_id_q]) begin
                        gnt_q       <= '0;
                        gnt_id_q    <= '0;
                        gnt_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end else if (MAX_HOLD != 0 && hold_cnt_q == HOLD_W'(MAX_HOLD)) begin
                        gnt_q       <= '0;
                        gnt_id_q    <= '0;
                        gnt_valid_q <= 1'b0;
                        mask_q      <= 8'(1) << gnt_id_q;
                        timeout_q   <= 1'b1;
                        state_q     <= IDLE;
                    end else if (hold_cnt_q != '1) begin
                        hold_cnt_q <= hold_cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign bus.gnt       = gnt_q;
    assign bus.gnt_id    = gnt_id_q;
    assign bus.gnt_valid = gnt_valid_q;
    assign bus.timeout   = timeout_q;
endmodule

// File: tb/tb_prio_req_arbiter_8.sv
// tb_prio_req_arbiter_8: directed bench for prio_req_arbiter_8 with MAX_HOLD=4.
module tb_prio_req_arbiter_8;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_chk = 0;
    int n_fail = 0;
    prio_req_arbiter_8_if bus();
    prio_req_arbiter_8 #(.MAX_HOLD(4), .HOLD_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
    always #5 clk = ~clk;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    // Expected gnt is derived from the expected index and valid flag.
    task automatic check(input string tag, input logic [2:0] id, input logic v, input logic to);
        logic [12:0] exp_v, obs_v;
        exp_v = {(v ? (8'(1) << id) : 8'h00), (v ? id : 3'd0), v, to};
        obs_v = {bus.gnt, bus.gnt_id, bus.gnt_valid, bus.timeout};
        n_chk++;
        assert (obs_v === exp_v) else begin
            n_fail++;
            $error("FAIL %s: got gnt=%b id=%0d v=%b to=%b, expected gnt=%b id=%0d v=%b to=%b",
                   tag, obs_v[12:5], obs_v[4:2], obs_v[1], obs_v[0],
                   exp_v[12:5], exp_v[4:2], exp_v[1], exp_v[0]);
        end
    endtask
    initial begin
`ifdef PRIO_ARB_ROUND_ROBIN_EN
        int order[9] = '{7, 6, 5, 4, 3, 2, 1, 0, 7};
`else
        int order[9] = '{7, 7, 7, 7, 7, 7, 7, 7, 7};
`endif
        bus.req = 8'h00;
        tick();
        tick();
        check("reset", 0, 0, 0);
        rst_n = 1'b1;
        bus.req = 8'b0010_0100;
        tick(); check("t1_grant5", 5, 1, 0);
        tick(); check("t1_hold5a", 5, 1, 0);
        tick(); check("t1_hold5b", 5, 1, 0);
        bus.req = 8'b0000_0100;
        tick(); check("t2_gap", 0, 0, 0);
        tick(); check("t2_grant2", 2, 1, 0);
        bus.req = 8'h00;
        tick(); check("t2_release", 0, 0, 0);
        tick(); check("t2_idle", 0, 0, 0);
        bus.req = 8'b1000_1000;
        for (int i = 1; i <= 4; i++) begin
            tick(); check($sformatf("t3_hold7_%0d", i), 7, 1, 0);
        end
        tick(); check("t3_timeout", 0, 0, 1);
        tick(); check("t3_masked_grant3", 3, 1, 0);
        bus.req = 8'b1000_0000;
        tick(); check("t3_gap", 0, 0, 0);
        tick(); check("t3_grant7", 7, 1, 0);
        bus.req = 8'h00;
        tick(); check("t3_release", 0, 0, 0);
        bus.req = 8'h80;
        for (int i = 1; i <= 4; i++) begin
            tick(); check($sformatf("t4_hold7_%0d", i), 7, 1, 0);
        end
        tick(); check("t4_timeout", 0, 0, 1);
        tick(); check("t4_mask_clear", 0, 0, 0);
        tick(); check("t4_regrant7", 7, 1, 0);
        tick(); check("t4_hold2", 7, 1, 0);
        tick(); check("t4_hold3", 7, 1, 0);
        tick(); check("t4_hold4", 7, 1, 0);
        bus.req = 8'h00;
        tick(); check("t4_release_no_timeout", 0, 0, 0);
        bus.req = 8'hFF;
        tick(); check("t5_grant7", 7, 1, 0);
        tick(); check("t5_hold7", 7, 1, 0);
        rst_n = 1'b0;
        tick(); check("t5_reset_mid_grant", 0, 0, 0);
        rst_n = 1'b1;
        tick(); check("t5_grant_after_reset", 7, 1, 0);
        bus.req = 8'h00;
        tick(); check("t5_release", 0, 0, 0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 9; k++) begin
            bus.req = 8'hFF;
            tick(); check($sformatf("t6_order_%0d", k), 3'(order[k]), 1, 0);
            bus.req = 8'hFF & ~(8'(1) << order[k]);
            tick(); check($sformatf("t6_gap_%0d", k), 0, 0, 0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
